// File: rtl/vend_countdown_timer.sv
// -----------------------------------------------------------------------------
// vend_countdown_timer
//
// Seconds countdown for the vending controller. The 1 Hz divider output is
// sampled as asynchronous data in the 50 MHz domain. Each rising edge becomes
// a one-cycle second tick, and the tick decrements a two-digit BCD count
// down to zero. The count drives the delivery/coin-return timeout and the
// seconds display.
//
// Parameters:
//   SYNC_STAGES  synchroniser depth on clk_1Hz (2..4)
//   WARN_SECS    warn threshold in seconds (0..99)
//
// Ports:
//   clk_50MHz    sole clock, rising edge
//   rst_n        asynchronous active-low reset
//   clk_1Hz      divider output, treated as asynchronous data
//   start        one-cycle request to load load_bcd and run
//   load_bcd     start value, [7:4] tens / [3:0] ones; digits above 9 clamp to 9
//   pause        level; freezes the count while high
//   cancel       one-cycle abort back to idle with the count cleared
//   tens, ones   remaining seconds (BCD)
//   busy         counting or paused
//   warn         busy and remaining seconds <= WARN_SECS
//   done         one-cycle pulse when the count reaches 00
//   expired      level, high while the timer sits at 00 after finishing
//   tick_out     one-cycle pulse per detected second edge, in every state
// -----------------------------------------------------------------------------
module vend_countdown_timer #(
  parameter int SYNC_STAGES = 2,
  parameter int WARN_SECS   = 5
) (
  input  logic       clk_50MHz,
  input  logic       rst_n,
  input  logic       clk_1Hz,
  input  logic       start,
  input  logic [7:0] load_bcd,
  input  logic       pause,
  input  logic       cancel,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       busy,
  output logic       warn,
  output logic       done,
  output logic       expired,
  output logic       tick_out
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_DONE
  } state_t;

  localparam int ARM_W = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [ARM_W-1:0]       arm_cnt;
  logic                   armed;
  logic                   edge_det;
  state_t                 state;
  logic                   done_pend;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  function automatic logic warn_for(input logic [3:0] t, input logic [3:0] o);
    return (int'(t) * 10 + int'(o)) <= WARN_SECS;
  endfunction

  // Synchroniser chain plus the previous-sample flop for edge detection.
  // The arm counter keeps detection off until the chain has fully refilled
  // after reset, so a clk_1Hz already high at release is not mistaken for an
  // edge against the reset-zero history.
  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge value of its neighbours; blocking = here would collapse the chain.
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      arm_cnt <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], clk_1Hz};
      prev_q <= sync_q[SYNC_STAGES-1];
      if (!armed) arm_cnt <= arm_cnt + ARM_W'(1);
    end
  end

  assign armed    = (arm_cnt == ARM_LAST);
  assign edge_det = armed && sync_q[SYNC_STAGES-1] && !prev_q;

  // Control FSM. Every output is a flop written alongside the state, so the
  // count, busy/warn and done all change on the same edge as tick_out.
  // Priority is cancel > start > pause > tick.
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      tens      <= 4'd0;
      ones      <= 4'd0;
      busy      <= 1'b0;
      warn      <= 1'b0;
      done      <= 1'b0;
      expired   <= 1'b0;
      tick_out  <= 1'b0;
      done_pend <= 1'b0;
    end else begin
      tick_out  <= edge_det;
      done      <= 1'b0;
      done_pend <= 1'b0;

      if (cancel) begin
        state   <= ST_IDLE;
        tens    <= 4'd0;
        ones    <= 4'd0;
        busy    <= 1'b0;
        warn    <= 1'b0;
        expired <= 1'b0;
      end else if (start && (state == ST_IDLE || state == ST_DONE)) begin
        tens <= clamp_digit(load_bcd[7:4]);
        ones <= clamp_digit(load_bcd[3:0]);
        // Clamping never turns a nonzero digit into zero, so the raw value
        // decides between running and finishing immediately.
        if (load_bcd == 8'h00) begin
          // A zero load finishes without a RUN cycle; done and expired are
          // raised one cycle later so they still rise together.
          state     <= ST_DONE;
          busy      <= 1'b0;
          warn      <= 1'b0;
          done_pend <= 1'b1;
        end else begin
          state   <= ST_RUN;
          busy    <= 1'b1;
          warn    <= warn_for(clamp_digit(load_bcd[7:4]), clamp_digit(load_bcd[3:0]));
          expired <= 1'b0;
        end
      end else begin
        unique case (state)
          ST_RUN: begin
            if (pause) begin
              // A tick landing on the pause edge is dropped, not deferred.
              state <= ST_PAUSE;
            end else if (edge_det) begin
              if (tens == 4'd0 && ones == 4'd1) begin
                state   <= ST_DONE;
                ones    <= 4'd0;
                busy    <= 1'b0;
                warn    <= 1'b0;
                done    <= 1'b1;
                expired <= 1'b1;
              end else if (ones == 4'd0) begin
                ones <= 4'd9;
                tens <= tens - 4'd1;
                warn <= warn_for(tens - 4'd1, 4'd9);
              end else begin
                ones <= ones - 4'd1;
                warn <= warn_for(tens, ones - 4'd1);
              end
            end
          end
          ST_PAUSE: begin
            // Ticks seen while paused are discarded, including on the
            // cycle pause is released.
            if (!pause) state <= ST_RUN;
          end
          ST_DONE: begin
            if (done_pend) begin
              done    <= 1'b1;
              expired <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vend_countdown_timer.sv
// -----------------------------------------------------------------------------
// tb_vend_countdown_timer
//
// Scoreboarded bench for vend_countdown_timer. The driver applies one input
// vector per clock at the falling edge, steps a behavioural model that keeps
// the remaining time as a plain integer, and queues the outputs expected
// after the next rising edge. A monitor pops and compares those entries just
// after each rising edge.
// -----------------------------------------------------------------------------
module tb_vend_countdown_timer;

  localparam int S    = 2;
  localparam int WARN = 5;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
    logic       busy;
    logic       warn;
    logic       done;
    logic       expired;
    logic       tick;
  } out_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clk_1hz;
  logic       start;
  logic [7:0] load_bcd;
  logic       pause;
  logic       cancel;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       busy;
  logic       warn;
  logic       done;
  logic       expired;
  logic       tick_out;

  vend_countdown_timer #(.SYNC_STAGES(S), .WARN_SECS(WARN)) dut (
    .clk_50MHz (clk),
    .rst_n     (rst_n),
    .clk_1Hz   (clk_1hz),
    .start     (start),
    .load_bcd  (load_bcd),
    .pause     (pause),
    .cancel    (cancel),
    .tens      (tens),
    .ones      (ones),
    .busy      (busy),
    .warn      (warn),
    .done      (done),
    .expired   (expired),
    .tick_out  (tick_out)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc_no = 0;
  out_t exp_q[$];

  // ---------------- behavioural reference model ----------------
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  int   m_mode;
  int   m_rem;
  bit   m_pend;
  bit   m_exp;
  bit   m_hist[$];   // clk_1Hz as seen at each edge since reset release

  task automatic model_reset();
    m_mode = M_IDLE;
    m_rem  = 0;
    m_pend = 0;
    m_exp  = 0;
    m_hist.delete();
  endtask

  function automatic int clamp9(input logic [3:0] d);
    return (d > 4'd9) ? 9 : int'(d);
  endfunction

  task automatic model_step(input logic st, input logic [7:0] ld, input logic pa,
                            input logic ca, input logic c1, output out_t e);
    int  k, j;
    bit  t, dn, fired;
    m_hist.push_back(c1);
    k = m_hist.size();
    // A rise first seen at sample j (j >= 2 after reset) ticks S edges later.
    j = k - S;
    t = (j >= 2) && m_hist[j-1] && !m_hist[j-2];
    dn = 0;
    fired = m_pend;
    m_pend = 0;
    if (ca) begin
      m_mode = M_IDLE; m_rem = 0; m_exp = 0;
    end else if (st && (m_mode == M_IDLE || m_mode == M_DONE)) begin
      m_rem = clamp9(ld[7:4]) * 10 + clamp9(ld[3:0]);
      if (m_rem > 0) begin
        m_mode = M_RUN; m_exp = 0;
      end else begin
        m_mode = M_DONE; m_pend = 1;
      end
    end else if (m_mode == M_RUN) begin
      if (pa) m_mode = M_PAUSE;
      else if (t) begin
        m_rem--;
        if (m_rem == 0) begin
          m_mode = M_DONE; dn = 1; m_exp = 1;
        end
      end
    end else if (m_mode == M_PAUSE) begin
      if (!pa) m_mode = M_RUN;
    end else if (m_mode == M_DONE && fired) begin
      dn = 1; m_exp = 1;
    end
    e.tens    = 4'(m_rem / 10);
    e.ones    = 4'(m_rem % 10);
    e.busy    = (m_mode == M_RUN || m_mode == M_PAUSE);
    e.warn    = e.busy && (m_rem <= WARN);
    e.done    = dn;
    e.expired = m_exp;
    e.tick    = t;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input out_t got, input out_t want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s cycle %0d: got tens=%0d ones=%0d busy=%b warn=%b done=%b expired=%b tick=%b, want tens=%0d ones=%0d busy=%b warn=%b done=%b expired=%b tick=%b",
               name, cyc_no, got.tens, got.ones, got.busy, got.warn, got.done, got.expired, got.tick,
               want.tens, want.ones, want.busy, want.warn, want.done, want.expired, want.tick);
    end
  endtask

  function automatic out_t dut_out();
    out_t o;
    o = '{tens: tens, ones: ones, busy: busy, warn: warn, done: done,
          expired: expired, tick: tick_out};
    return o;
  endfunction

  initial begin : monitor
    out_t e;
    forever begin
      @(posedge clk);
      #2;
      cyc_no++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("outputs", dut_out(), e);
      end
    end
  end

  // ---------------- driver ----------------
  logic c1 = 1'b0;
  bit   auto_c1 = 0;
  int   c1_left = 2;

  task automatic cyc(input logic st, input logic [7:0] ld, input logic pa, input logic ca);
    out_t e;
    @(negedge clk);
    if (auto_c1) begin
      if (c1_left <= 1) begin
        c1 = ~c1;
        c1_left = $urandom_range(2, 4);
      end else c1_left--;
    end
    start = st; load_bcd = ld; pause = pa; cancel = ca; clk_1hz = c1;
    model_step(st, ld, pa, ca, c1, e);
    exp_q.push_back(e);
  endtask

  task automatic hold(input int n, input logic pa);
    repeat (n) cyc(1'b0, 8'h00, pa, 1'b0);
  endtask

  task automatic secs(input int n, input logic pa);
    repeat (n) begin
      c1 = 1'b1; hold($urandom_range(2, 3), pa);
      c1 = 1'b0; hold($urandom_range(2, 3), pa);
    end
  endtask

  // Asserts reset mid-cycle, checks outputs clear at once, releases away
  // from the rising edge so the model and DUT agree on the first edge.
  task automatic do_reset(input logic c1_during);
    out_t zero;
    zero = '0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    start = 0; load_bcd = 0; pause = 0; cancel = 0;
    c1 = c1_during; clk_1hz = c1;
    #1 check("async_reset", dut_out(), zero);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    model_reset();
  endtask

  initial begin : driver
    rst_n = 1'b0;
    c1 = 1'b1; clk_1hz = 1'b1;
    start = 0; load_bcd = 0; pause = 0; cancel = 0;
    model_reset();
    #2 check("reset_state", dut_out(), out_t'('0));
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // clk_1Hz high through reset release: no tick until a real low-high.
    hold(10, 0);
    c1 = 1'b0; hold(3, 0);
    c1 = 1'b1; hold(5, 0);
    c1 = 1'b0; hold(3, 0);

    // 0x12 counts down through warn to done and stays expired.
    cyc(1, 8'h12, 0, 0);
    secs(13, 0);
    hold(4, 0);

    // 0x03 with a pause whose rising edge coincides with a tick.
    cyc(1, 8'h03, 0, 0);
    hold(3, 0);
    c1 = 1'b1;
    repeat (S) cyc(0, 8'h00, 0, 0);
    cyc(0, 8'h00, 1, 0);
    hold(2, 1);
    c1 = 1'b0; hold(2, 1);
    secs(4, 1);
    secs(4, 0);
    hold(3, 0);

    // Cancel wins over a simultaneous start; a fresh start follows.
    cyc(1, 8'h09, 0, 0);
    secs(2, 0);
    cyc(1, 8'h42, 0, 1);
    cyc(1, 8'h05, 0, 0);
    secs(3, 0);
    hold(2, 0);

    // Digit clamping, then a zero load straight to done.
    cyc(0, 8'h00, 0, 1);
    cyc(1, 8'hAF, 0, 0);
    secs(2, 0);
    cyc(0, 8'h00, 0, 1);
    cyc(1, 8'h00, 0, 0);
    hold(4, 0);
    cyc(1, 8'hFA, 0, 0);
    hold(2, 0);

    // Reset in the middle of a count; afterwards ticks do not count.
    cyc(0, 8'h00, 0, 1);
    cyc(1, 8'h06, 0, 0);
    secs(2, 0);
    do_reset(1'b1);
    hold(6, 0);
    secs(3, 0);

    // Randomised traffic with free-running clk_1Hz.
    auto_c1 = 1;
    begin
      logic pa_lvl = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        logic       st, ca;
        logic [7:0] ld;
        if ($urandom_range(0, 24) == 0) pa_lvl = ~pa_lvl;
        st = ($urandom_range(0, 29) == 0);
        ca = ($urandom_range(0, 99) == 0);
        ld = ($urandom_range(0, 3) == 0) ? 8'($urandom) : {4'h0, 4'($urandom_range(0, 9))};
        cyc(st, ld, pa_lvl, ca);
      end
    end
    auto_c1 = 0;

    @(posedge clk);
    #3;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
